// File: rtl/mux_pkg.sv
// Shared constants and types for the MUX datapath and its output FIFO.
package mux_pkg;

  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 4;

  typedef logic [DATA_W-1:0] data_t;

endpackage : mux_pkg

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port, no reset.
module fifo_mem
  import mux_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int DEPTH = FIFO_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule : fifo_mem

// File: rtl/mux_out_fifo.sv
// First-word-fall-through FIFO buffering the MUX X output for the next consumer.
// Optional sticky overflow flag when MUX_FIFO_OVF_EN is defined.
module mux_out_fifo
  import mux_pkg::*;
#(
  parameter  int WIDTH = DATA_W,
  parameter  int DEPTH = FIFO_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count
`ifdef MUX_FIFO_OVF_EN
  ,
  output logic             overflow
`endif
);

  // Handshake: a push is accepted when wr_en && !full, a pop when rd_en && !empty;
  // refused requests are dropped silently, nothing is held over to a later cycle.
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [WIDTH-1:0] head;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign push_ok = wr_en && !full;
  assign pop_ok  = rd_en && !empty;

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wr_ptr),
    .wdata (din),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // Masking with empty keeps never-written storage off dout.
  assign dout = empty ? '0 : head;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push_ok && !pop_ok) begin
        count <= count + (AW+1)'(1);
      end else if (pop_ok && !push_ok) begin
        count <= count - (AW+1)'(1);
      end
    end
  end

`ifdef MUX_FIFO_OVF_EN
  // A push against a full FIFO that is draining the same cycle is a refusal, not an error.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (wr_en && full && !rd_en) begin
      overflow <= 1'b1;
    end
  end
`endif

endmodule : mux_out_fifo

// File: tb/tb_mux_out_fifo.sv
// Directed self-checking bench for mux_out_fifo; covers the overflow flag when MUX_FIFO_OVF_EN is defined.
module tb_mux_out_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = '0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] dout;
  logic       empty;
  logic       full;
  logic [2:0] count;
`ifdef MUX_FIFO_OVF_EN
  logic       overflow;
  logic       exp_ovf = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  mux_out_fifo dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .dout     (dout),
    .empty    (empty),
    .full     (full),
    .count    (count)
`ifdef MUX_FIFO_OVF_EN
    ,
    .overflow (overflow)
`endif
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard comparison of all visible state against the queue model
  task automatic check_model(input string tag);
    logic [7:0] head;
    head = (exp_q.size() == 0) ? 8'h00 : exp_q[0];
    check({tag, "_count"}, 32'(count), 32'(exp_q.size()));
    check({tag, "_empty"}, 32'(empty), 32'(exp_q.size() == 0));
    check({tag, "_full"},  32'(full),  32'(exp_q.size() == 4));
    check({tag, "_dout"},  32'(dout),  32'(head));
`ifdef MUX_FIFO_OVF_EN
    check({tag, "_ovf"},   32'(overflow), 32'(exp_ovf));
`endif
  endtask

  // driver: one clock with given request, model updated with the accepted operations
  task automatic cycle(input logic w, input logic r, input logic [7:0] d);
    int n;
    n = exp_q.size();
    wr_en = w;
    rd_en = r;
    din   = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
`ifdef MUX_FIFO_OVF_EN
    if (w && n == 4 && !r) exp_ovf = 1'b1;
`endif
    if (r && n > 0) void'(exp_q.pop_front());
    if (w && n < 4) exp_q.push_back(d);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
`ifdef MUX_FIFO_OVF_EN
    exp_ovf = 1'b0;
`endif
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] v);
    check(tag, 32'(dout), 32'(v));
    cycle(1'b0, 1'b1, 8'h00);
  endtask

  initial begin
    // reset with a push request active must not load anything
    @(posedge clk);
    #1;
    wr_en = 1'b1;
    din   = 8'hAA;
    do_reset(2);
    wr_en = 1'b0;
    check("rst_empty", 32'(empty), 1);
    check("rst_full",  32'(full),  0);
    check("rst_count", 32'(count), 0);
    check("rst_dout",  32'(dout),  0);

    // fill and drain order
    cycle(1'b1, 1'b0, 8'hAA);
    check("lat_dout", 32'(dout), 32'hAA);
    cycle(1'b1, 1'b0, 8'h55);
    cycle(1'b1, 1'b0, 8'hFA);
    cycle(1'b1, 1'b0, 8'h0F);
    check("fill_full",  32'(full),  1);
    check("fill_count", 32'(count), 4);
    cycle(1'b1, 1'b0, 8'h11);
    check("ovr_count", 32'(count), 4);
    check_model("ovr");
    pop_expect("drain0", 8'hAA);
    pop_expect("drain1", 8'h55);
    pop_expect("drain2", 8'hFA);
    pop_expect("drain3", 8'h0F);
    check("drained_empty", 32'(empty), 1);
    check("drained_dout",  32'(dout),  0);
    cycle(1'b0, 1'b1, 8'h00);
    check_model("pop_empty");

    // wrap-around
    cycle(1'b1, 1'b0, 8'h21);
    cycle(1'b1, 1'b0, 8'h22);
    cycle(1'b1, 1'b0, 8'h23);
    repeat (3) cycle(1'b0, 1'b1, 8'h00);
    for (int i = 1; i <= 4; i++) cycle(1'b1, 1'b0, 8'(i));
    check_model("wrap_full");
    pop_expect("wrap0", 8'h01);
    pop_expect("wrap1", 8'h02);
    pop_expect("wrap2", 8'h03);
    pop_expect("wrap3", 8'h04);
    check_model("wrap_end");

    // simultaneous push+pop at count=2
    cycle(1'b1, 1'b0, 8'hA1);
    cycle(1'b1, 1'b0, 8'hA2);
    cycle(1'b1, 1'b1, 8'h77);
    check("sim2_count", 32'(count), 2);
    pop_expect("sim2_a", 8'hA2);
    pop_expect("sim2_b", 8'h77);
    // at count=0: only the push lands
    cycle(1'b1, 1'b1, 8'h77);
    check("sim0_count", 32'(count), 1);
    check("sim0_dout",  32'(dout),  32'h77);
    cycle(1'b0, 1'b1, 8'h00);
    // at count=4: pop accepted, push lost
    cycle(1'b1, 1'b0, 8'hB1);
    cycle(1'b1, 1'b0, 8'hB2);
    cycle(1'b1, 1'b0, 8'hB3);
    cycle(1'b1, 1'b0, 8'hB4);
    cycle(1'b1, 1'b1, 8'h88);
    check("sim4_count", 32'(count), 3);
    check_model("sim4");
    pop_expect("sim4_a", 8'hB2);
    pop_expect("sim4_b", 8'hB3);
    pop_expect("sim4_c", 8'hB4);
    check("sim4_empty", 32'(empty), 1);

    // mid-operation reset
    cycle(1'b1, 1'b0, 8'hD1);
    cycle(1'b1, 1'b0, 8'hD2);
    cycle(1'b1, 1'b0, 8'hD3);
    do_reset(1);
    check("mrst_count", 32'(count), 0);
    check("mrst_empty", 32'(empty), 1);
    wr_en = 1'b1;
    din   = 8'hC3;
    #1;
    check("nobypass_dout", 32'(dout), 0);
    cycle(1'b1, 1'b0, 8'hC3);
    check("mrst_push", 32'(dout), 32'hC3);
    check_model("mrst");

`ifdef MUX_FIFO_OVF_EN
    do_reset(1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'(8'hE0 + i));
    check("ovf_before", 32'(overflow), 0);
    cycle(1'b1, 1'b0, 8'h99);
    check("ovf_set", 32'(overflow), 1);
    repeat (4) cycle(1'b0, 1'b1, 8'h00);
    check("ovf_sticky", 32'(overflow), 1);
    check_model("ovf_drained");
    do_reset(1);
    check("ovf_cleared", 32'(overflow), 0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'(8'hE0 + i));
    cycle(1'b1, 1'b1, 8'h99);
    check("ovf_pushpop", 32'(overflow), 0);
    check_model("ovf_pushpop");
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_mux_out_fifo
